// File: rtl/frog_checker_if.sv
// rtl/frog_checker_if.sv - PRBS checker control/data/status bundle
interface frog_checker_if #(
  parameter int ERR_W = 16
);
  logic             load;
  logic             program_bit;
  logic             en;
  logic             rx_bit;
  logic             clear;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output load, program_bit, en, rx_bit, clear,
    input  locked, err, err_count
  );

  modport slave (
    input  load, program_bit, en, rx_bit, clear,
    output locked, err, err_count
  );
endinterface

// File: rtl/frog_checker.sv
// rtl/frog_checker.sv - self-synchronising serial PRBS checker with error counting
module frog_checker #(
  parameter int N         = 8,
  parameter int ERR_W     = 16,
  parameter int LOCK_GOOD = 16,
  parameter int LOSS_ERR  = 4
) (
  input logic            clk,
  input logic            rst_n,
  frog_checker_if.slave  bus
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_GOOD + 1);
  localparam int CW = $clog2(LOSS_ERR + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [N-1:0]     taps_q, taps_n;
  logic [N-1:0]     win_q, win_n;
  logic [FW-1:0]    fill_q, fill_n;
  logic [MW-1:0]    match_q, match_n;
  logic [CW-1:0]    cons_q, cons_n;
  logic             err_q, err_n;
  logic [ERR_W-1:0] err_count_q, err_count_n;

  logic exp_bit;
  logic miss;

  // Prediction of the next received bit from the recovered generator state
  assign exp_bit = ^(win_q & taps_q);
  assign miss    = (bus.rx_bit != exp_bit);

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      taps_q      <= '0;
      win_q       <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      cons_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_n;
      taps_q      <= taps_n;
      win_q       <= win_n;
      fill_q      <= fill_n;
      match_q     <= match_n;
      cons_q      <= cons_n;
      err_q       <= err_n;
      err_count_q <= err_count_n;
    end
  end

  // Next-state logic: taps programming overrides bit processing; clear acts on the counter alone
  always_comb begin
    state_n     = state_q;
    taps_n      = taps_q;
    win_n       = win_q;
    fill_n      = fill_q;
    match_n     = match_q;
    cons_n      = cons_q;
    err_n       = 1'b0;
    err_count_n = err_count_q;

    if (bus.load) begin
      taps_n      = {bus.program_bit, taps_q[N-1:1]};
      state_n     = SEARCH;
      fill_n      = '0;
      match_n     = '0;
      cons_n      = '0;
      err_count_n = '0;
    end else if (bus.en) begin
      case (state_q)
        SEARCH: begin
          win_n = {bus.rx_bit, win_q[N-1:1]};
          if (fill_q == FW'(N - 1)) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end else begin
            fill_n = fill_q + FW'(1);
          end
        end
        VERIFY: begin
          win_n = {bus.rx_bit, win_q[N-1:1]};
          if (miss) begin
            match_n = '0;
          end else if (match_q == MW'(LOCK_GOOD - 1)) begin
            state_n = LOCKED;
            match_n = '0;
            cons_n  = '0;
          end else begin
            match_n = match_q + MW'(1);
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a corrupted bit never pollutes the window
          win_n = {exp_bit, win_q[N-1:1]};
          if (miss) begin
            err_n = 1'b1;
            if (err_count_q != '1) begin
              err_count_n = err_count_q + ERR_W'(1);
            end
            if (cons_q == CW'(LOSS_ERR - 1)) begin
              state_n = SEARCH;
              fill_n  = '0;
              cons_n  = '0;
            end else begin
              cons_n = cons_q + CW'(1);
            end
          end else begin
            cons_n = '0;
          end
        end
        default: begin
          state_n = SEARCH;
          fill_n  = '0;
        end
      endcase
    end

    if (bus.clear) begin
      err_count_n = '0;
    end
  end

endmodule

// File: tb/tb_frog_checker.sv
// tb/tb_frog_checker.sv - directed self-checking bench for frog_checker
module tb_frog_checker;

  localparam int ERR_W = 4;
  localparam logic [7:0] TAPS = 8'hB8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frog_checker_if #(.ERR_W(ERR_W)) bus ();

  frog_checker #(
    .N(8), .ERR_W(ERR_W), .LOCK_GOOD(16), .LOSS_ERR(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] g;
  logic [7:0] gtaps;
  int exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 1'b0;
    bus.program_bit = 1'b0;
    bus.en = 1'b0;
    bus.rx_bit = 1'b0;
    bus.clear = 1'b0;
  endtask

  // One valid generator bit, optionally inverted, optionally with clear
  task automatic gen_bit(input logic inv, input logic clr);
    bus.load = 1'b0;
    bus.en = 1'b1;
    bus.rx_bit = g[0] ^ inv;
    bus.clear = clr;
    tick();
    g = {^(g & gtaps), g[7:1]};
    bus.en = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic program_taps(input logic [7:0] t, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.load = 1'b1;
      bus.program_bit = t[i];
      bus.en = 1'b0;
      tick();
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load = 1'($urandom_range(0, 1));
      bus.program_bit = 1'($urandom_range(0, 1));
      bus.en = 1'($urandom_range(0, 1));
      bus.rx_bit = 1'($urandom_range(0, 1));
      bus.clear = 1'($urandom_range(0, 1));
      tick();
    end
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", bus.locked); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'd0) $display("FAIL reset_err_count got %0d want 0", bus.err_count); else pass_cnt++;
    idle_inputs();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_acquire();
    int errs;
    program_taps(TAPS, 0, 7);
    gtaps = TAPS;
    g = 8'h01;
    for (int i = 0; i < 23; i++) gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL acquire_not_yet got %b want 0", bus.locked); else pass_cnt++;
    gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b1) $display("FAIL acquire_lock24 got %b want 1", bus.locked); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      gen_bit(1'b0, 1'b0);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) errs++;
    end
    total_cnt++; if (errs != 0) $display("FAIL acquire_clean_run got %0d bad cycles want 0", errs); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'd0) $display("FAIL acquire_err_count got %0d want 0", bus.err_count); else pass_cnt++;
  endtask

  task automatic test_single_error();
    int errs;
    gen_bit(1'b1, 1'b0);
    exp_cnt++;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL single_err_pulse got %b want 1", bus.err); else pass_cnt++;
    gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL single_err_width got %b want 0", bus.err); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'(exp_cnt)) $display("FAIL single_err_count got %0d want %0d", bus.err_count, exp_cnt); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      gen_bit(1'b0, 1'b0);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) errs++;
    end
    total_cnt++; if (errs != 0) $display("FAIL single_no_followon got %0d bad cycles want 0", errs); else pass_cnt++;
  endtask

  task automatic test_loss();
    for (int i = 0; i < 3; i++) begin
      gen_bit(1'b1, 1'b0);
      exp_cnt++;
      total_cnt++; if (bus.locked !== 1'b1) $display("FAIL loss_hold%0d got %b want 1", i, bus.locked); else pass_cnt++;
    end
    gen_bit(1'b1, 1'b0);
    exp_cnt++;
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL loss_unlock got %b want 0", bus.locked); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL loss_last_err got %b want 1", bus.err); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'(exp_cnt)) $display("FAIL loss_err_count got %0d want %0d", bus.err_count, exp_cnt); else pass_cnt++;
    for (int i = 0; i < 23; i++) gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL relock_early got %b want 0", bus.locked); else pass_cnt++;
    gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b1) $display("FAIL relock24 got %b want 1", bus.locked); else pass_cnt++;
  endtask

  task automatic test_en_hold();
    int errs;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      bus.en = 1'b0;
      bus.rx_bit = 1'($urandom_range(0, 1));
      tick();
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) errs++;
    end
    for (int i = 0; i < 10; i++) begin
      gen_bit(1'b0, 1'b0);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) errs++;
    end
    total_cnt++; if (errs != 0) $display("FAIL en_hold got %0d bad cycles want 0", errs); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'(exp_cnt)) $display("FAIL en_hold_count got %0d want %0d", bus.err_count, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      gen_bit(1'b1, 1'b0);
      for (int j = 0; j < 3; j++) gen_bit(1'b0, 1'b0);
    end
    exp_cnt = (exp_cnt + 20 > 15) ? 15 : exp_cnt + 20;
    total_cnt++; if (bus.err_count !== 4'(exp_cnt)) $display("FAIL sat_count got %0d want %0d", bus.err_count, exp_cnt); else pass_cnt++;
    total_cnt++; if (bus.locked !== 1'b1) $display("FAIL sat_locked got %b want 1", bus.locked); else pass_cnt++;
    gen_bit(1'b1, 1'b1);
    exp_cnt = 0;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL clear_err_pulse got %b want 1", bus.err); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'd0) $display("FAIL clear_count got %0d want 0", bus.err_count); else pass_cnt++;
    gen_bit(1'b0, 1'b0);
    gen_bit(1'b1, 1'b0);
    exp_cnt = 1;
    total_cnt++; if (bus.err_count !== 4'(exp_cnt)) $display("FAIL clear_resume got %0d want %0d", bus.err_count, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_load_while_locked();
    int valid;
    bus.load = 1'b1;
    bus.program_bit = TAPS[0];
    bus.en = 1'b1;
    bus.rx_bit = 1'($urandom_range(0, 1));
    tick();
    idle_inputs();
    exp_cnt = 0;
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL load_unlock got %b want 0", bus.locked); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'd0) $display("FAIL load_count got %0d want 0", bus.err_count); else pass_cnt++;
    program_taps(TAPS, 1, 7);
    valid = 0;
    for (int c = 0; c < 200 && valid < 23; c++) begin
      if (c % 2 == 0) begin
        gen_bit(1'b0, 1'b0);
        valid++;
      end else begin
        bus.en = 1'b0;
        bus.rx_bit = 1'($urandom_range(0, 1));
        tick();
      end
    end
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL toggle_early got %b want 0", bus.locked); else pass_cnt++;
    bus.en = 1'b0;
    tick();
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL toggle_idle got %b want 0", bus.locked); else pass_cnt++;
    gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b1) $display("FAIL toggle_lock24 got %b want 1", bus.locked); else pass_cnt++;
  endtask

  task automatic test_reset_mid_program();
    program_taps(8'h07, 0, 2);
    rst_n = 1'b0;
    bus.load = 1'b1;
    bus.program_bit = 1'b1;
    bus.en = 1'b1;
    bus.clear = 1'b0;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL midrst_locked got %b want 0", bus.locked); else pass_cnt++;
    total_cnt++; if (bus.err_count !== 4'd0) $display("FAIL midrst_count got %0d want 0", bus.err_count); else pass_cnt++;
    program_taps(TAPS, 3, 7);
    g = 8'h01;
    for (int i = 0; i < 24; i++) gen_bit(1'b0, 1'b0);
    total_cnt++; if (bus.locked !== 1'b1) $display("FAIL midrst_relock got %b want 1", bus.locked); else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_acquire();
    test_single_error();
    test_loss();
    test_en_hold();
    test_saturation();
    test_load_while_locked();
    test_reset_mid_program();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
